// File: rtl/elevator_pkg.sv
// Shared floor codes, scheduler state codes and defaults for the elevator call scheduler.
package elevator_pkg;

    localparam int unsigned FLOORS          = 4;
    localparam int unsigned DOOR_CYCLES_DEF = 8;

    localparam logic [1:0] GROUND = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;
    localparam logic [1:0] THIRD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_t;

    function automatic logic [FLOORS-1:0] floor_onehot(input logic [1:0] floor);
        return 4'b0001 << floor;
    endfunction

endpackage

// File: rtl/elevator_call_picker.sv
// Combinational SCAN helper: nearest pending floor strictly ahead of the car, and whether
// anything is pending strictly behind it.
module elevator_call_picker
    import elevator_pkg::*;
(
    input  logic [FLOORS-1:0] pending,
    input  logic [1:0]        cur_floor,
    input  logic              dir_up,
    output logic              ahead_valid,
    output logic [1:0]        ahead_floor,
    output logic              any_behind
);

    logic [FLOORS-1:0] above;
    logic [FLOORS-1:0] below;
    logic [FLOORS-1:0] ahead;
    logic [FLOORS-1:0] behind;

    always_comb begin
        above = '0;
        below = '0;
        unique case (cur_floor)
            GROUND: begin above = pending & 4'b1110; below = 4'b0000;           end
            FIRST:  begin above = pending & 4'b1100; below = pending & 4'b0001; end
            SECOND: begin above = pending & 4'b1000; below = pending & 4'b0011; end
            THIRD:  begin above = 4'b0000;           below = pending & 4'b0111; end
        endcase

        ahead       = dir_up ? above : below;
        behind      = dir_up ? below : above;
        ahead_valid = |ahead;
        any_behind  = |behind;

        // Nearest ahead: lowest set bit going up, highest set bit going down.
        ahead_floor = cur_floor;
        if (dir_up) begin
            for (int i = FLOORS - 1; i >= 0; i--) begin
                if (ahead[i]) ahead_floor = 2'(i);
            end
        end else begin
            for (int i = 0; i < FLOORS; i++) begin
                if (ahead[i]) ahead_floor = 2'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a 4-floor car: latches calls, picks targets, sequences door dwell.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DOOR_CYCLES = DOOR_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] call_req,
    input  logic [1:0]        cur_floor,
    output logic [1:0]        target_floor,
    output logic              door_open,
    output logic              dir_up,
    output logic              busy,
    output logic [FLOORS-1:0] pending
);

    localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        target_d;
    logic              door_d;
    logic              dir_d;
    logic              busy_d;
    logic [FLOORS-1:0] pending_d;
    logic [FLOORS-1:0] clr;

    logic              ahead_valid;
    logic [1:0]        ahead_floor;
    logic              any_behind;

    elevator_call_picker u_picker (
        .pending     (pending),
        .cur_floor   (cur_floor),
        .dir_up      (dir_up),
        .ahead_valid (ahead_valid),
        .ahead_floor (ahead_floor),
        .any_behind  (any_behind)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_floor;
        door_d   = door_open;
        dir_d    = dir_up;

        case (state_q)
            S_IDLE: begin
                target_d = cur_floor;
                if (pending[cur_floor]) begin
                    state_d = S_DOOR;
                    door_d  = 1'b1;
                    cnt_d   = DOOR_LAST;
                end else if (|pending) begin
                    state_d = S_MOVING;
                    if (!ahead_valid && any_behind) dir_d = ~dir_up;
                end
            end
            S_MOVING: begin
                if (cur_floor == target_floor && pending[cur_floor]) begin
                    state_d  = S_DOOR;
                    door_d   = 1'b1;
                    cnt_d    = DOOR_LAST;
                    target_d = cur_floor;
                end else if (ahead_valid) begin
                    target_d = ahead_floor;
                end else begin
                    // Only calls behind: park in IDLE, which reverses the sweep.
                    state_d = S_IDLE;
                end
            end
            S_DOOR: begin
                target_d = cur_floor;
                door_d   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    door_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                door_d  = 1'b0;
            end
        endcase

        // Served floor is cleared on door entry and throughout the dwell, beating new calls.
        clr       = (state_q == S_DOOR || state_d == S_DOOR) ? floor_onehot(cur_floor) : '0;
        pending_d = (pending | call_req) & ~clr;
        busy_d    = (state_d != S_IDLE) || (|pending_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            target_floor <= GROUND;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            busy         <= 1'b0;
            pending      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_floor <= target_d;
            door_open    <= door_d;
            dir_up       <= dir_d;
            busy         <= busy_d;
            pending      <= pending_d;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Closed-loop bench: scheduler driving a one-floor-per-cycle car, checked against a SCAN model.
module tb_elevator_call_scheduler;

    localparam int DOOR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] call_req = 4'b0000;
    logic [1:0] cur_floor;
    logic [1:0] target_floor;
    logic       door_open;
    logic       dir_up;
    logic       busy;
    logic [3:0] pending;

    int checks;
    int errors;

    // Reference model state
    int       m_mode;   // 0 idle, 1 moving, 2 door
    bit [3:0] m_pend;
    int       m_tgt;
    int       m_cur;
    int       m_left;
    bit       m_door;
    bit       m_up;
    bit       m_busy;

    elevator_call_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .call_req     (call_req),
        .cur_floor    (cur_floor),
        .target_floor (target_floor),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .busy         (busy),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    // Elevator car: one floor per cycle toward its target input.
    always @(posedge clk) begin
        if (rst) cur_floor <= 2'd0;
        else if (cur_floor < target_floor) cur_floor <= cur_floor + 2'd1;
        else if (cur_floor > target_floor) cur_floor <= cur_floor - 2'd1;
    end

    function automatic logic [10:0] dut_snap();
        return {cur_floor, target_floor, door_open, dir_up, busy, pending};
    endfunction

    function automatic logic [10:0] model_snap();
        return {2'(m_cur), 2'(m_tgt), m_door, m_up, m_busy, m_pend};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
    task automatic cycle(input logic [3:0] c, input logic r);
        int       n_mode, n_tgt, n_cur, n_left, ahead;
        bit [3:0] n_pend;
        bit       n_door, n_up, n_busy;
        call_req = c;
        rst      = r;
        if (r) begin
            n_mode = 0; n_pend = 0; n_tgt = 0; n_cur = 0; n_left = 0;
            n_door = 0; n_up = 1; n_busy = 0;
        end else begin
            n_cur = m_cur;
            if (m_tgt > m_cur) n_cur = m_cur + 1;
            if (m_tgt < m_cur) n_cur = m_cur - 1;
            ahead = -1;
            for (int f = 0; f < 4; f++) begin
                if (m_pend[f] && ((m_up && f > m_cur) || (!m_up && f < m_cur))) begin
                    if (ahead < 0 || (m_up ? f < ahead : f > ahead)) ahead = f;
                end
            end
            n_mode = m_mode; n_tgt = m_tgt; n_door = m_door; n_up = m_up; n_left = m_left;
            if (m_mode == 0) begin
                n_tgt = m_cur;
                if (m_pend[m_cur]) begin
                    n_mode = 2; n_door = 1; n_left = DOOR - 1;
                end else if (m_pend != 0) begin
                    n_mode = 1;
                    if (ahead < 0) n_up = !m_up;
                end
            end else if (m_mode == 1) begin
                if (m_cur == m_tgt && m_pend[m_cur]) begin
                    n_mode = 2; n_door = 1; n_left = DOOR - 1; n_tgt = m_cur;
                end else if (ahead >= 0) begin
                    n_tgt = ahead;
                end else begin
                    n_mode = 0;
                end
            end else begin
                n_tgt = m_cur;
                if (m_left == 0) begin
                    n_mode = 0; n_door = 0;
                end else begin
                    n_left = m_left - 1;
                end
            end
            n_pend = m_pend | c;
            if (m_mode == 2 || n_mode == 2) n_pend[m_cur] = 1'b0;
            n_busy = (n_mode != 0) || (n_pend != 0);
        end
        @(posedge clk);
        m_mode = n_mode; m_pend = n_pend; m_tgt = n_tgt; m_cur = n_cur;
        m_left = n_left; m_door = n_door; m_up = n_up; m_busy = n_busy;
        #1;
    endtask

    task automatic test_reset();
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        checks++;
        if (dut_snap() !== 11'b00_00_0_1_0_0000) begin
            errors++;
            $display("FAIL reset_state got %b want %b", dut_snap(), 11'b00_00_0_1_0_0000);
        end
        cycle(4'b0000, 1'b0);
        checks++;
        if (dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL reset_idle got %b want %b", dut_snap(), model_snap());
        end
    endtask

    task automatic test_sweep_up();
        int doors = 0;
        int first = -1;
        bit early = 0;
        for (int i = 0; i <= 20; i++) begin
            cycle((i == 0) ? 4'b1000 : 4'b0000, 1'b0);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL sweep_up cyc %0d got %b want %b", i, dut_snap(), model_snap());
            end
            if (door_open) begin
                doors++;
                if (first < 0) first = i;
                if (cur_floor != 2'd3) early = 1;
            end
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL sweep_up_arrival got %0d want %0d", first, 6);
        end
        checks++;
        if (doors !== DOOR || early) begin
            errors++;
            $display("FAIL sweep_up_dwell got %0d early %0d want %0d early 0", doors, early, DOOR);
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL sweep_up_pending got %b want 0000", pending);
        end
    endtask

    task automatic test_reverse();
        int doors = 0;
        int first = -1;
        for (int i = 0; i <= 20; i++) begin
            cycle((i == 0) ? 4'b0001 : 4'b0000, 1'b0);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL reverse cyc %0d got %b want %b", i, dut_snap(), model_snap());
            end
            if (i == 1) begin
                checks++;
                if (dir_up !== 1'b0) begin
                    errors++;
                    $display("FAIL reverse_dir got %b want 0", dir_up);
                end
            end
            if (door_open) begin
                doors++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first !== 6 || doors !== DOOR || cur_floor !== 2'd0) begin
            errors++;
            $display("FAIL reverse_stop got first %0d doors %0d floor %0d want 6 %0d 0",
                     first, doors, cur_floor, DOOR);
        end
    endtask

    task automatic test_preempt();
        int  stops[$];
        int  doors = 0;
        bit  prev  = 0;
        for (int i = 0; i <= 35; i++) begin
            cycle((i == 0) ? 4'b1000 : (i == 1) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL preempt cyc %0d got %b want %b", i, dut_snap(), model_snap());
            end
            if (door_open) doors++;
            if (door_open && !prev) stops.push_back(int'(cur_floor));
            prev = door_open;
        end
        checks++;
        if (stops.size() != 2 || stops[0] != 1 || stops[1] != 3 || doors != 2 * DOOR) begin
            errors++;
            $display("FAIL preempt_stops got %0d stops first %0d doors %0d want 2 stops 1,3 %0d",
                     stops.size(), (stops.size() > 0) ? stops[0] : -1, doors, 2 * DOOR);
        end
    endtask

    task automatic test_dwell_absorb();
        int  n = 0;
        bit  reached = 0;
        cycle(4'b0100, 1'b0);
        while (!door_open && n < 20) begin
            cycle(4'b0000, 1'b0);
            n++;
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL absorb_seek cyc %0d got %b want %b", n, dut_snap(), model_snap());
            end
        end
        checks++;
        if (!door_open || cur_floor !== 2'd2) begin
            errors++;
            $display("FAIL absorb_door_timeout got door %b floor %0d want 1 2", door_open, cur_floor);
        end
        for (int k = 0; k < 6; k++) begin
            cycle((k == 0) ? 4'b0101 : 4'b0100, 1'b0);
            checks++;
            if (pending[2] !== 1'b0 || dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL absorb_hold cyc %0d got %b want %b", k, dut_snap(), model_snap());
            end
        end
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL absorb_other got %b want 1", pending[0]);
        end
        n = 0;
        while (!reached && n < 30) begin
            cycle(4'b0000, 1'b0);
            n++;
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL absorb_down cyc %0d got %b want %b", n, dut_snap(), model_snap());
            end
            if (door_open && cur_floor == 2'd0) reached = 1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL absorb_reach0 got floor %0d want 0 with door", cur_floor);
        end
        for (int k = 0; k < DOOR; k++) cycle(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cycle(4'b1000, 1'b0);
        while (cur_floor != 2'd1 && n < 10) begin
            cycle(4'b0000, 1'b0);
            n++;
        end
        checks++;
        if (cur_floor !== 2'd1 || target_floor !== 2'd3) begin
            errors++;
            $display("FAIL resetmid_setup got floor %0d tgt %0d want 1 3", cur_floor, target_floor);
        end
        cycle(4'b0000, 1'b1);
        checks++;
        if (dut_snap() !== 11'b00_00_0_1_0_0000 || dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL resetmid got %b want %b", dut_snap(), 11'b00_00_0_1_0_0000);
        end
    endtask

    task automatic test_all_calls();
        int stops[$];
        bit prev = 0;
        for (int i = 0; i <= 50; i++) begin
            cycle((i == 0) ? 4'b1111 : 4'b0000, 1'b0);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL all_calls cyc %0d got %b want %b", i, dut_snap(), model_snap());
            end
            if (door_open && !prev) stops.push_back(int'(cur_floor));
            prev = door_open;
        end
        checks++;
        if (stops.size() != 4 || stops[0] != 0 || stops[1] != 1 || stops[2] != 2 || stops[3] != 3)
        begin
            errors++;
            $display("FAIL all_calls_order got %0d stops want 4 stops 0,1,2,3", stops.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic       r;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            r = ($urandom_range(0, 150) == 0);
            cycle(c, r);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, dut_snap(), model_snap());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_mode = 0; m_pend = 0; m_tgt = 0; m_cur = 0; m_left = 0;
        m_door = 0; m_up = 1; m_busy = 0;
        test_reset();
        test_sweep_up();
        test_reverse();
        test_preempt();
        test_dwell_absorb();
        test_reset_mid();
        test_all_calls();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
